// File: rtl/img_pkg.sv
// Shared definitions for the UART-to-BRAM image loader.
// Holds the default image geometry, the bus widths and the loader state type.
package img_pkg;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int ADDR_W    = 18;  // enough for 2^18 pixels
  localparam int PIX_W     = 24;  // {R,G,B}
  localparam int TO_W      = 20;  // idle counter width, covers 1_000_000

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;
endpackage

// File: rtl/bram_load_ctrl_if.sv
// Byte-in / pixel-write bus of the image loader.
//   rx_ready, rx_data : UART byte strobe and byte
//   wea, line, wdata  : BRAM write enable, pixel address, packed pixel
//   busy, frame_done, timeout_err : status
// master = the loader, slave = the UART / BRAM side.
interface bram_load_ctrl_if;
  import img_pkg::*;

  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              wea;
  logic [ADDR_W-1:0] line;
  logic [PIX_W-1:0]  wdata;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  modport master (
    input  rx_ready, rx_data,
    output wea, line, wdata, busy, frame_done, timeout_err
  );
  modport slave (
    output rx_ready, rx_data,
    input  wea, line, wdata, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/rx_timeout.sv
// Idle-gap watchdog for the loader.
//   clk, rst : clock, synchronous active-high reset
//   clear    : a byte arrived this cycle, restart the count
//   enable   : count only while loading; held at 0 otherwise
//   expired  : this cycle is the LIMIT-th consecutive idle cycle
module rx_timeout
  import img_pkg::*;
#(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_W-1:0] count;

  // Fires on the cycle the count would reach LIMIT, so a byte in that
  // same cycle (clear) suppresses the abort.
  assign expired = enable && !clear && (count == TO_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable || clear || expired) count <= '0;
    else                                    count <= count + 1'b1;
  end
endmodule

// File: rtl/bram_load_ctrl.sv
// Assembles UART bytes R,G,B into 24-bit pixels and writes them row-major
// into the frame-buffer BRAMs, one pixel per single-cycle wea pulse.
//   CLK100MHZ, rst : clock, synchronous active-high reset
//   bus (master)   : rx_ready/rx_data in; wea/line/wdata BRAM write port,
//                    busy, frame_done pulse, sticky timeout_err out
module bram_load_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W          = DEF_IMG_W,
  parameter int IMG_H          = DEF_IMG_H,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  bram_load_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

  load_state_t       state;
  logic [1:0]        phase;
  logic [7:0]        r_byte, g_byte;
  logic              wea, busy, frame_done, timeout_err;
  logic [ADDR_W-1:0] line;
  logic [PIX_W-1:0]  wdata;
  logic              expired;

  rx_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (CLK100MHZ),
    .rst     (rst),
    .clear   (bus.rx_ready),
    .enable  (state == LOAD),
    .expired (expired)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 2'd0;
      r_byte      <= '0;
      g_byte      <= '0;
      wea         <= 1'b0;
      line        <= '0;
      wdata       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;

      // Byte capture is state independent: a byte landing in the write
      // cycle or in DONE simply starts the next pixel.
      if (bus.rx_ready) begin
        timeout_err <= 1'b0;
        unique case (phase)
          2'd0:    begin r_byte <= bus.rx_data; phase <= 2'd1; end
          2'd1:    begin g_byte <= bus.rx_data; phase <= 2'd2; end
          default: begin
            wdata <= {r_byte, g_byte, bus.rx_data};
            wea   <= 1'b1;
            phase <= 2'd0;
          end
        endcase
      end

      unique case (state)
        IDLE: if (bus.rx_ready) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          if (expired) begin
            state       <= IDLE;
            busy        <= 1'b0;
            phase       <= 2'd0;
            line        <= '0;
            timeout_err <= 1'b1;
          end else if (wea) begin
            if (line == LAST) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              line       <= '0;
            end else begin
              line <= line + 1'b1;
            end
          end
        end
        DONE: begin
          // A partial pixel can exist here if a byte arrived in the final
          // write cycle; keep loading rather than dropping it.
          if (bus.rx_ready || phase != 2'd0) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wea         = wea;
  assign bus.line        = line;
  assign bus.wdata       = wdata;
  assign bus.busy        = busy;
  assign bus.frame_done  = frame_done;
  assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_bram_load_ctrl.sv
// Self-checking bench for bram_load_ctrl (4x2 image, 50-cycle timeout).
module tb_bram_load_ctrl;
  import img_pkg::*;

  localparam int W = 4, H = 2, TO = 50, NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_load_ctrl_if bus ();

  bram_load_ctrl #(.IMG_W(W), .IMG_H(H), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus.master)
  );

  int total = 0, bad = 0;

  // observed side
  int          obs_line[$];
  logic [23:0] obs_data[$];
  int          obs_done = 0, dbl = 0;
  logic        wea_q = 1'b0;

  always @(negedge clk) begin
    if (bus.wea) begin
      obs_line.push_back(int'(bus.line));
      obs_data.push_back(bus.wdata);
      if (wea_q) dbl++;
    end
    if (bus.frame_done) obs_done++;
    wea_q = bus.wea;
  end

  // reference model: bytes group into pixels of three; a frame ends after
  // NPIX pixels; a gap of TO or more idle cycles inside a frame drops it.
  logic [7:0]  part[$];
  int          midx = 0, idle_run = 0, exp_done = 0;
  int          exp_line[$];
  logic [23:0] exp_data[$];

  function automatic void model_byte(logic [7:0] b, int gap);
    if (gap >= TO && (midx != 0 || part.size() != 0)) begin
      part.delete();
      midx = 0;
    end
    part.push_back(b);
    if (part.size() == 3) begin
      exp_line.push_back(midx);
      exp_data.push_back({part[0], part[1], part[2]});
      part.delete();
      midx++;
      if (midx == NPIX) begin
        midx = 0;
        exp_done++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) begin tick(); idle_run++; end
  endtask

  task automatic send(logic [7:0] b);
    model_byte(b, idle_run);
    idle_run = 0;
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic fresh();
    rst = 1'b1; bus.rx_ready = 1'b0;
    tick();
    rst = 1'b0;
    part.delete(); midx = 0; idle_run = 0; exp_done = 0;
    exp_line.delete(); exp_data.delete();
    obs_line.delete(); obs_data.delete(); obs_done = 0; dbl = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rx_ready = 1'b1; bus.rx_data = 8'h5A;
    repeat (3) tick();
    total++;
    if ({bus.wea, bus.line, bus.wdata, bus.busy, bus.frame_done, bus.timeout_err} !== '0) begin
      bad++; $display("FAIL reset_outs got wea=%b line=%0d wdata=%h busy=%b done=%b err=%b want all 0",
                      bus.wea, bus.line, bus.wdata, bus.busy, bus.frame_done, bus.timeout_err);
    end
    bus.rx_ready = 1'b0; rst = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.line !== '0) begin
      bad++; $display("FAIL reset_prio got busy=%b line=%0d want 0/0", bus.busy, bus.line);
    end
  endtask

  task automatic test_frame();
    fresh();
    for (int i = 0; i < 24; i++) begin send(8'(i)); idle(3); end
    idle(3);
    total++;
    if (obs_line.size() !== exp_line.size()) begin
      bad++; $display("FAIL frame_nwr got=%0d want=%0d", obs_line.size(), exp_line.size());
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL frame_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
    total++;
    if (obs_data.size() != 8 || obs_data[0] !== 24'h000102 || obs_data[7] !== 24'h151617) begin
      bad++; $display("FAIL frame_ends got n=%0d want first=000102 last=151617", obs_data.size());
    end
    total++;
    if (obs_done !== 1 || bus.line !== '0 || bus.busy !== 1'b0 || dbl !== 0) begin
      bad++; $display("FAIL frame_done got done=%0d line=%0d busy=%b dbl=%0d want 1/0/0/0", obs_done, bus.line, bus.busy, dbl);
    end
  endtask

  task automatic test_timeout();
    fresh();
    for (int i = 0; i < 4; i++) begin send(8'($urandom)); idle(1); end
    // last byte went in at cycle t; we now sit in idle cycle 2
    for (int k = 2; k <= 60; k++) begin
      if (k == 49) begin
        total++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL to_early got err=%b busy=%b want 0/1", bus.timeout_err, bus.busy);
        end
      end
      if (k == 51) begin
        total++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.line !== '0) begin
          bad++; $display("FAIL to_abort got err=%b busy=%b line=%0d want 1/0/0", bus.timeout_err, bus.busy, bus.line);
        end
      end
      idle(1);
    end
    total++;
    if (obs_line.size() !== 1 || obs_line[0] !== 0) begin
      bad++; $display("FAIL to_onewr got n=%0d want 1 at line 0", obs_line.size());
    end
    send(8'($urandom));
    total++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL to_clear got err=%b busy=%b want 0/1", bus.timeout_err, bus.busy);
    end
    send(8'($urandom)); send(8'($urandom));
    idle(3);
    total++;
    if (obs_line.size() !== exp_line.size()) begin
      bad++; $display("FAIL to_nwr got=%0d want=%0d", obs_line.size(), exp_line.size());
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL to_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_race();
    fresh();
    send(8'h11); idle(1); send(8'h22);
    idle(TO - 1);
    send(8'h33);  // lands in the 50th idle cycle
    total++;
    if (bus.timeout_err !== 1'b0 || bus.wea !== 1'b1 || bus.line !== '0 || bus.wdata !== 24'h112233) begin
      bad++; $display("FAIL race got err=%b wea=%b line=%0d wdata=%h want 0/1/0/112233",
                      bus.timeout_err, bus.wea, bus.line, bus.wdata);
    end
    idle(3);
    total++;
    if (obs_line.size() !== exp_line.size() || exp_line.size() != 1 || obs_data[0] !== exp_data[0]) begin
      bad++; $display("FAIL race_wr got n=%0d want n=%0d", obs_line.size(), exp_line.size());
    end
  endtask

  task automatic test_reset_mid();
    fresh();
    for (int i = 0; i < 10; i++) begin send(8'($urandom)); idle($urandom_range(0, 3)); end
    rst = 1'b1; tick(); rst = 1'b0;
    part.delete(); midx = 0; idle_run = 0;
    total++;
    if ({bus.wea, bus.line, bus.wdata, bus.busy, bus.frame_done, bus.timeout_err} !== '0) begin
      bad++; $display("FAIL rmid_outs got wea=%b line=%0d wdata=%h busy=%b want all 0", bus.wea, bus.line, bus.wdata, bus.busy);
    end
    for (int i = 0; i < 24; i++) begin send(8'($urandom)); idle($urandom_range(0, 3)); end
    idle(3);
    total++;
    if (obs_line.size() !== exp_line.size() || obs_done !== exp_done) begin
      bad++; $display("FAIL rmid_nwr got=%0d/%0d want=%0d/%0d", obs_line.size(), obs_done, exp_line.size(), exp_done);
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL rmid_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_done_byte();
    fresh();
    for (int i = 0; i < 23; i++) begin send(8'($urandom)); idle($urandom_range(0, 2)); end
    send(8'($urandom));
    idle(1);       // write cycle of line 7
    send(8'hAA);   // DONE cycle
    total++;
    if (bus.busy !== 1'b1 || obs_done !== 1) begin
      bad++; $display("FAIL done_byte got busy=%b done=%0d want 1/1", bus.busy, obs_done);
    end
    send(8'($urandom)); send(8'($urandom));
    idle(3);
    total++;
    if (obs_line.size() !== 9 || obs_line[8] !== 0 || obs_data[8][23:16] !== 8'hAA) begin
      bad++; $display("FAIL done_next got n=%0d want 9 with last at line 0 R=aa", obs_line.size());
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL done_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fresh();
    for (int i = 0; i < 24; i++) send(8'($urandom));
    idle(4);
    total++;
    if (obs_line.size() !== 8 || obs_done !== 1 || dbl !== 0) begin
      bad++; $display("FAIL b2b got n=%0d done=%0d dbl=%0d want 8/1/0", obs_line.size(), obs_done, dbl);
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL b2b_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    fresh();
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 19) == 0) idle($urandom_range(60, 70));
      else                            idle($urandom_range(0, 4));
    end
    idle(4);
    total++;
    if (obs_line.size() !== exp_line.size() || obs_done !== exp_done || dbl !== 0) begin
      bad++; $display("FAIL rnd_cnt got n=%0d done=%0d dbl=%0d want n=%0d done=%0d dbl=0",
                      obs_line.size(), obs_done, dbl, exp_line.size(), exp_done);
    end
    for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
      total++;
      if (obs_line[i] !== exp_line[i] || obs_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL rnd_wr%0d got=%0d/%h want=%0d/%h", i, obs_line[i], obs_data[i], exp_line[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_frame();
    test_timeout();
    test_race();
    test_reset_mid();
    test_done_byte();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_load_ctrl.md
BRAM_LOAD_CTRL -- requirements
Module: bram_load_ctrl

Interface
REQ-001 Parameter IMG_W, default 320, image width in pixels.
REQ-002 Parameter IMG_H, default 240, image height in pixels; IMG_W*IMG_H SHALL be at most 2^18.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, idle cycles that abort a partial frame (10 ms at 100 MHz).
REQ-004 CLK100MHZ  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_ready  input  1  one-cycle strobe marking a valid UART byte.
REQ-007 rx_data  input  8  UART byte, valid when rx_ready=1.
REQ-008 wea  output  1  BRAM write enable, shared by all nine buffer BRAMs.
REQ-009 line  output  18  BRAM write address, pixel index, row-major.
REQ-010 wdata  output  24  packed pixel {R,G,B}.
REQ-011 busy  output  1  high while in LOAD.
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-013 timeout_err  output  1  sticky abort flag.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DONE.
REQ-015 IDLE: line=0, byte phase=0; rx_ready SHALL capture the byte as R and move to LOAD.
REQ-016 LOAD: bytes SHALL be captured in order R (wdata[23:16]), G (wdata[15:8]), B (wdata[7:0]) via a 2-bit phase counter 0->1->2->0.
REQ-017 On the B byte strobe in cycle t, wea SHALL be 1 in cycle t+1 only, with wdata holding the full pixel and line holding the current pixel index.
REQ-018 line SHALL increment by 1 in the cycle after each write; wea is never high for more than one consecutive cycle.
REQ-019 After the write at line=IMG_W*IMG_H-1, the FSM SHALL enter DONE, line SHALL reset to 0, and frame_done SHALL pulse for exactly one cycle while in DONE.
REQ-020 DONE SHALL last one cycle and then go to IDLE; an rx_ready during DONE SHALL be captured as R of the next frame and go directly to LOAD.
REQ-021 In LOAD, a 20-bit idle counter SHALL clear on every rx_ready and increment otherwise. Reaching TIMEOUT_CYCLES SHALL drop the partial pixel, reset line and phase to 0, set timeout_err, and return to IDLE without a write.
REQ-022 If rx_ready coincides with the timeout cycle, the byte SHALL win: the byte is accepted, the counter clears, and no abort occurs.
REQ-023 timeout_err SHALL stay set until the first byte of the next frame is accepted, then clear.
REQ-024 The idle counter SHALL be held at 0 outside LOAD.
REQ-025 wdata SHALL hold its last value when wea=0; line SHALL not exceed IMG_W*IMG_H-1.

Reset
REQ-026 While rst=1: state=IDLE; wea=0, line=0, wdata=0, busy=0, frame_done=0, timeout_err=0; phase=0; idle counter=0.
REQ-027 rst SHALL take priority over rx_ready and timeout in the same cycle.
REQ-028 Reset mid-frame SHALL discard the partial pixel and frame with no write.

Structure
REQ-029 Package img_pkg SHALL hold IMG_W, IMG_H defaults, ADDR_W=18, PIX_W=24, and the state enum load_state_t.
REQ-030 The idle timeout counter SHALL be a sub-module named rx_timeout (inputs clear/enable; output expired).
REQ-031 The block SHALL contain no BRAM; it drives the existing nine-BRAM write ports (wea, addra=line, dina=wdata) in top.

Verification
REQ-032 The bench SHALL use IMG_W=4, IMG_H=2, TIMEOUT_CYCLES=50.
REQ-033 Scenario 1: 24 bytes 0x00..0x17, 3 idle cycles apart -> 8 single-cycle writes at line 0..7, first wdata=0x000102, last wdata=0x151617; frame_done pulses once after the line=7 write; line returns to 0.
REQ-034 Scenario 2: 4 bytes, then 60 idle cycles -> exactly 1 write (line 0); timeout_err=1 and state=IDLE at idle cycle 50; next byte clears timeout_err and starts at line 0.
REQ-035 Scenario 3: 2 bytes, then rx_ready on exactly the 50th idle cycle -> no abort; the byte is taken as B and written at line 0.
REQ-036 Scenario 4: rst asserted for 1 cycle after 10 bytes -> all outputs 0 the next cycle; a following 24-byte frame writes line 0..7 correctly.
REQ-037 Scenario 5: a byte 0xAA arrives in the DONE cycle of a frame -> busy=1 the next cycle, and the next frame's first write has wdata[23:16]=0xAA at line 0.
REQ-038 Scenario 6: back-to-back rx_ready on every cycle for 24 bytes -> 8 writes, none lost, frame_done exactly once.
